// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges pipeline writeback and buffered mult/div results onto one register file write port
module rf_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int AW         = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pl_wr,
  input  logic [4:0]    pl_addr,
  input  logic [31:0]   pl_data,
  output logic          pl_stall,
  input  logic          md_issue,
  input  logic [4:0]    md_issue_addr,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [4:0]    md_addr,
  input  logic [31:0]   md_data,
  output logic          rf_wr,
  output logic [4:0]    rf_addr,
  output logic [31:0]   rf_data,
  input  logic [4:0]    q_addr1,
  input  logic [4:0]    q_addr2,
  output logic          q_busy1,
  output logic          q_busy2,
  output logic [AW:0]   fifo_count
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   busy;
  logic          empty, pl_req, push, forced, pop, pl_win;
  logic [4:0]    head_addr;
  logic [31:0]   head_data, set_mask, clr_mask;
  always_comb begin
    empty     = fifo_count == '0;
    md_ready  = fifo_count < FULL;
    push      = md_valid && md_ready && |md_addr;
    pl_req    = pl_wr && |pl_addr;
    forced    = !empty && starve_cnt == SMAX;
    pop       = !empty && (forced || !pl_req);
    pl_win    = pl_req && !forced;
    pl_stall  = pl_req && forced;
    head_addr = fifo_addr[rd_ptr];
    head_data = fifo_data[rd_ptr];
    set_mask  = (md_issue && |md_issue_addr) ? 32'(1) << md_issue_addr : '0;
    clr_mask  = pop ? 32'(1) << head_addr : '0;
    q_busy1   = |q_addr1 && busy[q_addr1];
    q_busy2   = |q_addr2 && busy[q_addr2];
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= md_addr;
      fifo_data[wr_ptr] <= md_data;
    end
  end
  // set_mask is applied after clr_mask so a same-cycle issue keeps the register busy
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_wr      <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      rf_wr <= pop || pl_win;
      if (pop) begin
        rf_addr <= head_addr;
        rf_data <= head_data;
      end else if (pl_win) begin
        rf_addr <= pl_addr;
        rf_data <= pl_data;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      starve_cnt <= (empty || pop) ? '0 : (pl_win && starve_cnt != SMAX) ? starve_cnt + SW'(1) : starve_cnt;
      busy       <= (busy & ~clr_mask) | set_mask;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed stimulus with a write scoreboard checked by an independent monitor
module tb_rf_write_arbiter;
  logic        clk, reset;
  logic        pl_wr, pl_stall, md_issue, md_valid, md_ready, rf_wr, q_busy1, q_busy2;
  logic [4:0]  pl_addr, md_issue_addr, md_addr, rf_addr, q_addr1, q_addr2;
  logic [31:0] pl_data, md_data, rf_data;
  logic [2:0]  fifo_count;
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  rf_write_arbiter dut (
    .clk(clk), .reset(reset),
    .pl_wr(pl_wr), .pl_addr(pl_addr), .pl_data(pl_data), .pl_stall(pl_stall),
    .md_issue(md_issue), .md_issue_addr(md_issue_addr),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .fifo_count(fifo_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_b(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask
  task automatic chk_w(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", n, act, exp);
    end
  endtask
  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_wr === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: rf_addr=%0d rf_data=0x%h, no write expected", rf_addr, rf_data);
        end else begin
          e = exp_q.pop_front();
          if (rf_addr !== e.a || rf_data !== e.d) begin
            errors++;
            $display("FAIL write_order: got addr=%0d data=0x%h expected addr=%0d data=0x%h", rf_addr, rf_data, e.a, e.d);
          end
        end
      end
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic busy_any;
    int   k;
    reset = 1'b0; pl_wr = 1'b0; pl_addr = '0; pl_data = '0;
    md_issue = 1'b0; md_issue_addr = '0; md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h77;
    q_addr1 = '0; q_addr2 = '0;
    step; step;
    chk_b("reset_rf_wr", rf_wr, 1'b0);
    chk_w("reset_rf_addr", 32'(rf_addr), 32'd0);
    chk_w("reset_rf_data", rf_data, 32'd0);
    chk_w("reset_fifo_count", 32'(fifo_count), 32'd0);
    busy_any = 1'b0;
    for (int a = 0; a < 32; a++) begin
      q_addr1 = 5'(a);
      #1;
      busy_any = busy_any | q_busy1;
    end
    chk_b("reset_busy_any", busy_any, 1'b0);
    md_valid = 1'b0; reset = 1'b1;
    step;
    chk_w("post_reset_fifo_count", 32'(fifo_count), 32'd0);
    // single pipeline write
    pl_wr = 1'b1; pl_addr = 5'd5; pl_data = 32'hDEADBEEF;
    #1 chk_b("pl_only_stall", pl_stall, 1'b0);
    expect_wr(5'd5, 32'hDEADBEEF);
    step;
    pl_wr = 1'b0;
    chk_b("pl_only_rf_wr", rf_wr, 1'b1);
    chk_w("pl_only_rf_addr", 32'(rf_addr), 32'd5);
    chk_w("pl_only_rf_data", rf_data, 32'hDEADBEEF);
    chk_b("pl_only_stall_after", pl_stall, 1'b0);
    // mult/div round trip through scoreboard
    q_addr1 = 5'd9; md_issue = 1'b1; md_issue_addr = 5'd9;
    #1 chk_b("busy9_before_issue", q_busy1, 1'b0);
    step;
    md_issue = 1'b0;
    #1 chk_b("busy9_after_issue", q_busy1, 1'b1);
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h12345678;
    expect_wr(5'd9, 32'h12345678);
    step;
    md_valid = 1'b0;
    #1 chk_w("md_buffered_count", 32'(fifo_count), 32'd1);
    chk_b("md_not_yet_written", rf_wr, 1'b0);
    chk_b("busy9_while_buffered", q_busy1, 1'b1);
    step;
    chk_b("md_rf_wr", rf_wr, 1'b1);
    chk_w("md_rf_addr", 32'(rf_addr), 32'd9);
    chk_w("md_rf_data", rf_data, 32'h12345678);
    chk_b("busy9_cleared", q_busy1, 1'b0);
    chk_w("md_drained_count", 32'(fifo_count), 32'd0);
    // starvation: forced pop every fourth cycle against constant pipeline traffic
    k = 0;
    for (int c = 0; c < 17; c++) begin
      logic stall_exp;
      pl_wr = 1'b1; pl_addr = 5'd3; pl_data = 32'h300 + 32'(k);
      md_valid = (c < 4); md_addr = 5'(10 + c); md_data = 32'hA0 + 32'(c);
      stall_exp = (c % 4 == 0) && (c > 0);
      #1;
      chk_b("starve_md_ready", md_ready, c != 4);
      chk_b("starve_pl_stall", pl_stall, stall_exp);
      if (c == 4) chk_w("starve_full_count", 32'(fifo_count), 32'd4);
      if (stall_exp) expect_wr(5'(10 + c / 4 - 1), 32'hA0 + 32'(c / 4 - 1));
      else begin
        expect_wr(5'd3, 32'h300 + 32'(k));
        k++;
      end
      step;
    end
    pl_wr = 1'b0; md_valid = 1'b0;
    #1 chk_w("starve_drained_count", 32'(fifo_count), 32'd0);
    // full FIFO: offered result during a pop is refused
    for (int c = 0; c < 4; c++) begin
      pl_wr = 1'b1; pl_addr = 5'd4; pl_data = 32'h400 + 32'(c);
      md_valid = 1'b1; md_addr = 5'(14 + c); md_data = 32'hB0 + 32'(c);
      expect_wr(5'd4, 32'h400 + 32'(c));
      step;
    end
    pl_wr = 1'b0; md_valid = 1'b1; md_addr = 5'd20; md_data = 32'hBAD;
    #1 chk_w("full_count", 32'(fifo_count), 32'd4);
    chk_b("full_md_ready", md_ready, 1'b0);
    expect_wr(5'd14, 32'hB0);
    step;
    md_valid = 1'b0;
    #1 chk_w("full_pop_count", 32'(fifo_count), 32'd3);
    expect_wr(5'd15, 32'hB1);
    expect_wr(5'd16, 32'hB2);
    expect_wr(5'd17, 32'hB3);
    step; step; step;
    chk_w("full_drained_count", 32'(fifo_count), 32'd0);
    // register 0 traffic is a no-op
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hBAD;
    #1 chk_b("r0_md_ready", md_ready, 1'b1);
    step;
    md_valid = 1'b0;
    #1 chk_w("r0_md_count", 32'(fifo_count), 32'd0);
    chk_b("r0_md_rf_wr", rf_wr, 1'b0);
    pl_wr = 1'b1; pl_addr = 5'd0; pl_data = 32'hBAD;
    #1 chk_b("r0_pl_stall", pl_stall, 1'b0);
    step;
    pl_wr = 1'b0;
    chk_b("r0_pl_rf_wr", rf_wr, 1'b0);
    // issue and pop of the same register in one cycle keeps it busy
    q_addr1 = 5'd9; q_addr2 = 5'd0; md_issue = 1'b1; md_issue_addr = 5'd9;
    step;
    md_issue = 1'b0; md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h55;
    step;
    md_valid = 1'b0; md_issue = 1'b1; md_issue_addr = 5'd9;
    expect_wr(5'd9, 32'h55);
    step;
    md_issue = 1'b0;
    #1 chk_b("setwins_rf_wr", rf_wr, 1'b1);
    chk_b("setwins_busy9", q_busy1, 1'b1);
    chk_b("busy_addr0", q_busy2, 1'b0);
    // reset mid-operation discards buffered results and pending bits
    pl_wr = 1'b1; pl_addr = 5'd3; pl_data = 32'h600;
    md_valid = 1'b1; md_addr = 5'd21; md_data = 32'h66;
    expect_wr(5'd3, 32'h600);
    step;
    md_valid = 1'b0; pl_data = 32'h601;
    #1 chk_w("midreset_count_before", 32'(fifo_count), 32'd1);
    reset = 1'b0;
    step;
    reset = 1'b1; pl_wr = 1'b0;
    #1 chk_w("midreset_count", 32'(fifo_count), 32'd0);
    chk_b("midreset_rf_wr", rf_wr, 1'b0);
    chk_b("midreset_busy9", q_busy1, 1'b0);
    step; step;
    chk_b("midreset_no_stale_write", rf_wr, 1'b0);
    step; step;
    chk_w("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
